// File: rtl/edge_frame_sequencer.sv
// Raster frame sequencer: frame-buffer reads to a VSYNC/HSYNC/DE stream.
// Define SEQ_FLUSH_EN to append V_FLUSH zero-valued flush lines per frame.
module edge_frame_sequencer #(
  parameter int WIDTH   = 8,
  parameter int H_RES   = 176,
  parameter int V_RES   = 144,
  parameter int H_BLANK = 16,
  parameter int VS_LEN  = 4,
  parameter int V_FLUSH = 2,
  parameter int ADDR_W  = $clog2(H_RES*V_RES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic              i_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [WIDTH-1:0]  i_rd_data,
  output logic              o_vsync,
  output logic              o_hsync,
  output logic              o_de,
  output logic [WIDTH-1:0]  o_data
);

  localparam int PW   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int LMAX = (V_RES > V_FLUSH) ? V_RES : V_FLUSH;
  localparam int LW   = (LMAX > 1) ? $clog2(LMAX) : 1;
  localparam int TMAX = (VS_LEN > H_BLANK) ? VS_LEN : H_BLANK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_LINE   = 3'd2,
    S_HBLANK = 3'd3,
`ifdef SEQ_FLUSH_EN
    S_FLUSH  = 3'd4,
`endif
    S_DONE   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     pix_q, pix_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [LW-1:0]     line_q, line_d;
  logic              fin_q, fin_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vs_q, hs_q, de_q, src_q;
`ifdef SEQ_FLUSH_EN
  logic              flush_q, flush_d;
`else
  logic              unused_flush;
  assign unused_flush = (V_FLUSH != 0);
`endif

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    tmr_d   = tmr_q;
    line_d  = line_q;
    fin_d   = fin_q;
    addr_d  = addr_q;
`ifdef SEQ_FLUSH_EN
    flush_d = flush_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        pix_d  = '0;
        tmr_d  = '0;
        line_d = '0;
        fin_d  = 1'b0;
        addr_d = '0;
`ifdef SEQ_FLUSH_EN
        flush_d = 1'b0;
`endif
        if (i_start) state_d = S_VSYNC;
      end
      S_VSYNC: begin
        if (tmr_q == TW'(VS_LEN-1)) begin
          tmr_d   = '0;
          state_d = S_LINE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_LINE: begin
        addr_d = addr_q + ADDR_W'(1);
        if (pix_q == PW'(H_RES-1)) begin
          pix_d   = '0;
          state_d = S_HBLANK;
          if (line_q == LW'(V_RES-1)) begin
            line_d = '0;
            fin_d  = 1'b1;
          end else begin
            line_d = line_q + LW'(1);
          end
        end else begin
          pix_d = pix_q + PW'(1);
        end
      end
      S_HBLANK: begin
        // hold only stretches the final counted blank cycle
        if (tmr_q != TW'(H_BLANK-1)) begin
          tmr_d = tmr_q + TW'(1);
        end else if (!i_hold) begin
          tmr_d = '0;
`ifdef SEQ_FLUSH_EN
          if (!fin_q) begin
            state_d = flush_q ? S_FLUSH : S_LINE;
          end else if (!flush_q && (V_FLUSH > 0)) begin
            state_d = S_FLUSH;
            flush_d = 1'b1;
            fin_d   = 1'b0;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = fin_q ? S_DONE : S_LINE;
`endif
        end
      end
`ifdef SEQ_FLUSH_EN
      S_FLUSH: begin
        if (pix_q == PW'(H_RES-1)) begin
          pix_d   = '0;
          state_d = S_HBLANK;
          if (line_q == LW'(V_FLUSH-1)) begin
            line_d = '0;
            fin_d  = 1'b1;
          end else begin
            line_d = line_q + LW'(1);
          end
        end else begin
          pix_d = pix_q + PW'(1);
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
        line_d  = '0;
        fin_d   = 1'b0;
`ifdef SEQ_FLUSH_EN
        flush_d = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      tmr_q   <= '0;
      line_q  <= '0;
      fin_q   <= 1'b0;
      addr_q  <= '0;
`ifdef SEQ_FLUSH_EN
      flush_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      tmr_q   <= tmr_d;
      line_q  <= line_d;
      fin_q   <= fin_d;
      addr_q  <= addr_d;
`ifdef SEQ_FLUSH_EN
      flush_q <= flush_d;
`endif
    end
  end

  // stream flags lag the state by one cycle to meet the RAM read latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_q  <= 1'b0;
      hs_q  <= 1'b0;
      de_q  <= 1'b0;
      src_q <= 1'b0;
    end else begin
      vs_q  <= (state_q == S_VSYNC);
      hs_q  <= (state_q == S_HBLANK) && (tmr_q == '0);
`ifdef SEQ_FLUSH_EN
      de_q  <= (state_q == S_LINE) || (state_q == S_FLUSH);
`else
      de_q  <= (state_q == S_LINE);
`endif
      src_q <= (state_q == S_LINE);
    end
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = (state_q == S_DONE);
  assign o_rd_en   = (state_q == S_LINE);
  assign o_rd_addr = addr_q;
  assign o_vsync   = vs_q;
  assign o_hsync   = hs_q;
  assign o_de      = de_q;
  assign o_data    = src_q ? i_rd_data : '0;

endmodule
